// File: rtl/pio_debounce_irq.sv
// General-purpose Avalon-MM I/O port with per-bit direction, synchronised and
// debounced inputs, programmable edge capture and a maskable level interrupt.
// Pin tristate buffers live at the system top level, driven by pio_out/pio_oe.
module pio_debounce_irq #(
   parameter int               WIDTH     = 8,
   parameter int               DB_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] pio_in,
   output logic [WIDTH-1:0] pio_out,
   output logic [WIDTH-1:0] pio_oe
);

   localparam int               CNT_W   = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_DIR    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_RISE   = 3'd4;
   localparam logic [2:0] ADDR_FALL   = 3'd5;
   localparam logic [2:0] ADDR_OUTSET = 3'd6;
   localparam logic [2:0] ADDR_OUTCLR = 3'd7;

   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wdata;
   logic             unused_wd;

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d;

   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] dir_reg;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] cap_reg;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;

   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [31:0]      rd_mux;

   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;
   assign wdata = writedata[WIDTH-1:0];

   // Bits of writedata above WIDTH carry no meaning for this port.
   assign unused_wd = ^writedata;

   // Two-flop synchroniser on every pin, independent of direction.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pio_in;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      logic [CNT_W-1:0] cnt;
      logic             deb_bit;

      // Accept a new input level only after it has differed from deb for DB_CYCLES edges.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            cnt     <= '0;
            deb_bit <= 1'b0;
         end else if (s2[i] == deb_bit) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            deb_bit <= s2[i];
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign deb[i] = deb_bit;
   end

   // Delayed copy of deb so edges are detected one cycle after deb moves.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         deb_d <= '0;
      end else begin
         deb_d <= deb;
      end
   end

   assign cap_set = (deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en);
   assign cap_clr = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;

   // Control registers written from the bus; OUTSET/OUTCLR modify out_reg in place.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         out_reg  <= RESET_OUT;
         dir_reg  <= '0;
         mask_reg <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:   out_reg  <= wdata;
            ADDR_DIR:    dir_reg  <= wdata;
            ADDR_MASK:   mask_reg <= wdata;
            ADDR_RISE:   rise_en  <= wdata;
            ADDR_FALL:   fall_en  <= wdata;
            ADDR_OUTSET: out_reg  <= out_reg | wdata;
            ADDR_OUTCLR: out_reg  <= out_reg & ~wdata;
            default:     ;
         endcase
      end
   end

   // Edge-capture bits: a new capture beats a simultaneous write-1-to-clear.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cap_reg <= '0;
      end else begin
         cap_reg <= (cap_reg & ~cap_clr) | cap_set;
      end
   end

   // Read multiplexer; DATA shows out_reg on output bits and debounced pins on inputs.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = (dir_reg & out_reg) | (~dir_reg & deb);
         ADDR_DIR:  rd_mux[WIDTH-1:0] = dir_reg;
         ADDR_MASK: rd_mux[WIDTH-1:0] = mask_reg;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = cap_reg;
         ADDR_RISE: rd_mux[WIDTH-1:0] = rise_en;
         ADDR_FALL: rd_mux[WIDTH-1:0] = fall_en;
         default:   rd_mux = '0;
      endcase
   end

   // Registered read data, held between reads.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         readdata <= '0;
      end else if (rd_en) begin
         readdata <= rd_mux;
      end
   end

   assign irq     = |(cap_reg & mask_reg);
   assign pio_out = out_reg;
   assign pio_oe  = dir_reg;

endmodule
